// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster timing generator (x, y, DE, syncs) plus the frame-buffer
// read address stage for a 2x-upscaled QVGA buffer. The address is issued one
// pixel period ahead of the matching timing outputs, which covers the RAM latency.
module vga_scan_timing #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int FB_W    = 320
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pixel_tick,
    output logic        h_sync,
    output logic        v_sync,
    output logic        DE,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic [16:0] rd_addr,
    output logic        rd_en
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [16:0] FB_W_C   = 17'(FB_W);

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic        tick_q, tick_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;

    logic        rd_en_q, rd_en_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic [9:0]  p_h_q, p_h_d;
    logic [9:0]  p_v_q, p_v_d;
    logic        p_valid_q, p_valid_d;

    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;

    logic        visible0;
    logic        visible1;
    logic [16:0] v_half;
    logic [16:0] h_half;
    logic [16:0] row_base;
    logic [16:0] addr_next;

    assign v_half    = {8'd0, v_cnt_q[9:1]};
    assign h_half    = {8'd0, h_cnt_q[9:1]};
    assign addr_next = row_base + h_half;

    // Row base address; the 320-wide buffer uses a shift-add instead of a multiplier.
    generate
        if (FB_W == 320) begin : g_shift_add
            assign row_base = (v_half << 8) + (v_half << 6);
        end else begin : g_mult
            assign row_base = v_half * FB_W_C;
        end
    endgenerate

    // Pixel-rate divider; the strobe is registered so it is high while div_cnt is at its last count.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
        tick_d    = (div_cnt_d == DIV_LAST);
    end

    // Raster counters advance once per pixel; h and v wrapping together land directly on (0,0).
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Stage 0: read address for the current raster position, plus a copy of that position for stage 1.
    always_comb begin
        visible0  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        rd_en_d   = tick_q && visible0;
        rd_addr_d = rd_addr_q;
        p_h_d     = p_h_q;
        p_v_d     = p_v_q;
        p_valid_d = p_valid_q;
        if (tick_q) begin
            p_h_d     = h_cnt_q;
            p_v_d     = v_cnt_q;
            p_valid_d = 1'b1;
            if (visible0) begin
                rd_addr_d = addr_next;
            end
        end
    end

    // Stage 1: decode syncs/DE/x/y from the position stage 0 addressed one pixel earlier.
    always_comb begin
        visible1 = (p_h_q < H_VIS_C) && (p_v_q < V_VIS_C);
        de_d     = de_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        x_d      = x_q;
        y_d      = y_q;
        fs_d     = 1'b0;
        if (tick_q && p_valid_q) begin
            de_d = visible1;
            hs_d = !((p_h_q >= HS_BEG) && (p_h_q < HS_END));
            vs_d = !((p_v_q >= VS_BEG) && (p_v_q < VS_END));
            fs_d = (p_h_q == 10'd0) && (p_v_q == 10'd0);
            if (visible1) begin
                x_d = p_h_q;
                y_d = p_v_q;
            end
        end
    end

    // Divider and raster counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= 4'd0;
            tick_q    <= 1'b0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= 17'd0;
            p_h_q     <= 10'd0;
            p_v_q     <= 10'd0;
            p_valid_q <= 1'b0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            p_h_q     <= p_h_d;
            p_v_q     <= p_v_d;
            p_valid_q <= p_valid_d;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            fs_q <= 1'b0;
            x_q  <= 10'd0;
            y_q  <= 10'd0;
        end else begin
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign DE          = de_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign frame_start = fs_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule
